// File: rtl/regfile_fill_sequencer_if.sv
// -----------------------------------------------------------------------------
// regfile_fill_sequencer_if
// Register-file / ALU control bundle between the fill sequencer and the
// register-file lab datapath.
//   rf_we       register-file write enable
//   rf_waddr    write address
//   rf_raddr_a  ALU operand A read address
//   rf_raddr_b  ALU operand B read address
//   alu_op      0 = ADD (A + Bsel), 1 = PASS_IMM (imm)
//   b_sel_imm   1 = operand B is imm, 0 = operand B is register-file port B
//   imm         immediate value
// Modports: master (sequencer drives), slave (datapath consumes).
// -----------------------------------------------------------------------------
interface regfile_fill_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [ADDR_W-1:0] rf_raddr_a;
    logic [ADDR_W-1:0] rf_raddr_b;
    logic              alu_op;
    logic              b_sel_imm;
    logic [DATA_W-1:0] imm;

    modport master (
        output rf_we, rf_waddr, rf_raddr_a, rf_raddr_b, alu_op, b_sel_imm, imm
    );

    modport slave (
        input rf_we, rf_waddr, rf_raddr_a, rf_raddr_b, alu_op, b_sel_imm, imm
    );
endinterface

// File: rtl/regfile_fill_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_fill_sequencer
// Control FSM for the register-file lab datapath. On start it fills all
// NREG = 2**ADDR_W registers with a mode-selected sequence (Fibonacci, powers
// of two, or a count), one write per cycle, then parks in DISPLAY where the
// switches drive the operand-A read address. A new start from DISPLAY refills
// without a reset.
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous, active-high
//   start     fill request (honoured in IDLE and DISPLAY only)
//   mode      0 Fibonacci, 1 shift, 2 count, 3 reserved (ignored)
//   switches  display read address
//   rf        register-file / ALU control bundle (master side)
//   busy      high while filling
//   done      high in DISPLAY
//   fsmState  state encoding for debug
// -----------------------------------------------------------------------------
module regfile_fill_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [1:0]                      mode,
    input  logic [ADDR_W-1:0]               switches,
    regfile_fill_sequencer_if.master        rf,
    output logic                            busy,
    output logic                            done,
    output logic [2:0]                      fsmState
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEED0   = 3'd1;
    localparam logic [2:0] S_SEED1   = 3'd2;
    localparam logic [2:0] S_STEP    = 3'd3;
    localparam logic [2:0] S_DISPLAY = 3'd4;

    localparam logic [1:0] M_FIB     = 2'd0;
    localparam logic [1:0] M_SHIFT   = 2'd1;
    localparam logic [1:0] M_RSVD    = 2'd3;

    // i carries one extra bit so the terminal compare never wraps.
    localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] TWO      = ONE + ONE;

    logic [2:0]      state;
    logic [ADDR_W:0] i;
    logic [1:0]      mode_q;
    logic [ADDR_W:0] i_m1;
    logic [ADDR_W:0] i_m2;

    assign i_m1     = i - ONE;
    assign i_m2     = i - TWO;
    assign fsmState = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            i      <= '0;
            mode_q <= 2'd0;
        end else begin
            case (state)
                S_IDLE, S_DISPLAY: begin
                    if (start && (mode != M_RSVD)) begin
                        state  <= S_SEED0;
                        mode_q <= mode;
                    end
                end
                S_SEED0: state <= S_SEED1;
                S_SEED1: begin
                    state <= S_STEP;
                    i     <= TWO;
                end
                S_STEP: begin
                    i <= i + ONE;
                    if (i == LAST_IDX) begin
                        state <= S_DISPLAY;
                    end
                end
                // Unused encodings fall back to IDLE.
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore decode; only DISPLAY passes switches straight through.
    always_comb begin
        rf.rf_we      = 1'b0;
        rf.rf_waddr   = '0;
        rf.rf_raddr_a = '0;
        rf.rf_raddr_b = '0;
        rf.alu_op     = 1'b0;
        rf.b_sel_imm  = 1'b0;
        rf.imm        = '0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            S_SEED0: begin
                rf.rf_we     = 1'b1;
                rf.alu_op    = 1'b1;
                rf.b_sel_imm = 1'b1;
                rf.imm       = (mode_q == M_SHIFT) ? DATA_W'(1) : DATA_W'(0);
                busy         = 1'b1;
            end
            S_SEED1: begin
                rf.rf_we     = 1'b1;
                rf.rf_waddr  = ADDR_W'(1);
                rf.alu_op    = 1'b1;
                rf.b_sel_imm = 1'b1;
                rf.imm       = (mode_q == M_SHIFT) ? DATA_W'(2) : DATA_W'(1);
                busy         = 1'b1;
            end
            S_STEP: begin
                rf.rf_we      = 1'b1;
                rf.rf_waddr   = i[ADDR_W-1:0];
                rf.rf_raddr_a = i_m1[ADDR_W-1:0];
                busy          = 1'b1;
                case (mode_q)
                    M_FIB:   rf.rf_raddr_b = i_m2[ADDR_W-1:0];
                    // Shift doubles by adding the previous register to itself.
                    M_SHIFT: rf.rf_raddr_b = i_m1[ADDR_W-1:0];
                    default: begin
                        rf.b_sel_imm = 1'b1;
                        rf.imm       = DATA_W'(1);
                    end
                endcase
            end
            S_DISPLAY: begin
                rf.rf_raddr_a = switches;
                done          = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_regfile_fill_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_fill_sequencer
// Drives the fill sequencer attached to a small register-file + ALU datapath
// and checks state timing, write sequence and readback values against
// sequences computed directly from the pattern definitions.
// -----------------------------------------------------------------------------
module tb_regfile_fill_sequencer;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int NREG   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b1;
    logic [1:0]        mode = 2'd0;
    logic [ADDR_W-1:0] switches = '0;
    logic              busy;
    logic              done;
    logic [2:0]        fsmState;

    int errors = 0;
    int checks = 0;

    regfile_fill_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rfb ();

    regfile_fill_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .switches (switches),
        .rf       (rfb),
        .busy     (busy),
        .done     (done),
        .fsmState (fsmState)
    );

    // Lab datapath: register file with combinational reads and an ALU.
    logic [DATA_W-1:0] regs [NREG];
    wire  [DATA_W-1:0] opa = regs[rfb.rf_raddr_a];
    wire  [DATA_W-1:0] opb = rfb.b_sel_imm ? rfb.imm : regs[rfb.rf_raddr_b];
    wire  [DATA_W-1:0] res = rfb.alu_op ? rfb.imm : DATA_W'(opa + opb);

    always @(posedge clk) begin
        if (rfb.rf_we) regs[rfb.rf_waddr] <= res;
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected register contents from the pattern definitions.
    function automatic logic [31:0] model(input int m, input int idx);
        int a, b, t;
        if (m == 1) return 32'(1 << idx);
        if (m == 2) return 32'(idx);
        a = 0;
        b = 1;
        for (int k = 0; k < idx; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return 32'(a & 16'hffff);
    endfunction

    task automatic run_fill(input int m, input bit kick);
        int edges;
        int we_cnt;
        int exp_state;
        edges  = 0;
        we_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = 2'(m);
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 2'($urandom_range(3, 0));
        check("seed0_state", 32'(fsmState), 32'd1);
        check("seed0_done", 32'(done), 32'd0);
        check("seed0_busy", 32'(busy), 32'd1);
        while (fsmState != 3'd4 && edges < 40) begin
            @(negedge clk);
            if (rfb.rf_we) begin
                check("waddr_seq", 32'(rfb.rf_waddr), 32'(we_cnt));
                we_cnt++;
            end
            if (m == 1 && fsmState == 3'd3) begin
                check("shift_raddr_a", 32'(rfb.rf_raddr_a), 32'((we_cnt - 2) % NREG));
                check("shift_raddr_b", 32'(rfb.rf_raddr_b), 32'((we_cnt - 2) % NREG));
            end
            if (kick && fsmState == 3'd3 && rfb.rf_waddr == 4'd7) begin
                start = 1'b1;
                mode  = 2'($urandom_range(2, 0));
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            exp_state = (edges == 1) ? 2 : (edges < NREG) ? 3 : 4;
            check("state_seq", 32'(fsmState), 32'(exp_state));
        end
        check("done_edge", 32'(edges), 32'(NREG));
        check("we_cycles", 32'(we_cnt), 32'(NREG));
        check("display_done", 32'(done), 32'd1);
        check("display_busy", 32'(busy), 32'd0);
        check("display_we", 32'(rfb.rf_we), 32'd0);
    endtask

    task automatic readback(input int m);
        int order [NREG];
        int j, t;
        for (int k = 0; k < NREG; k++) order[k] = k;
        for (int k = NREG - 1; k > 0; k--) begin
            j = int'($urandom_range(k, 0));
            t = order[k];
            order[k] = order[j];
            order[j] = t;
        end
        for (int k = 0; k < NREG; k++) begin
            switches = ADDR_W'(order[k]);
            #1;
            check("rd_addr", 32'(rfb.rf_raddr_a), 32'(order[k]));
            check("rd_data", 32'(regs[rfb.rf_raddr_a]), model(m, order[k]));
        end
    endtask

    task automatic reset_midfill(input int prev_m);
        int target;
        int guard;
        target = int'($urandom_range(14, 3));
        guard  = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        while (!(fsmState == 3'd3 && int'(rfb.rf_waddr) == target) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("midfill_reached", 32'(guard < 40), 32'd1);
        reset = 1'b1;
        #1;
        check("midfill_rst_state", 32'(fsmState), 32'd0);
        check("midfill_rst_we", 32'(rfb.rf_we), 32'd0);
        check("midfill_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midfill_hold_state", 32'(fsmState), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            check("midfill_regs", 32'(regs[k]), (k < target) ? model(0, k) : model(prev_m, k));
        end
    endtask

    initial begin
        // Reset held with start asserted.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst_state", 32'(fsmState), 32'd0);
            check("rst_we", 32'(rfb.rf_we), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("idle_raddr_a", 32'(rfb.rf_raddr_a), 32'd0);

        // Reserved mode is ignored in IDLE.
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mode3_idle", 32'(fsmState), 32'd0);
        repeat ($urandom_range(3, 0)) @(posedge clk);

        run_fill(0, 1'b0);
        readback(0);
        run_fill(1, 1'b1);
        readback(1);

        // Reserved mode is ignored in DISPLAY too.
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mode3_display", 32'(fsmState), 32'd4);

        run_fill(2, 1'b0);
        readback(2);
        reset_midfill(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
